// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encodings for the UART LED command parser.
package uart_cmd_pkg;

   localparam logic [7:0] CHAR_L  = 8'h4C;
   localparam logic [7:0] CHAR_CR = 8'h0D;
   localparam logic [7:0] CHAR_LF = 8'h0A;

   localparam int INDEX_DIGITS  = 2;
   localparam int COLOUR_DIGITS = 6;
   localparam int LAT_W         = 4;

   typedef enum logic [1:0] {
      F_IDLE,
      F_REQ,
      F_WAIT
   } fetch_state_t;

   typedef enum logic [2:0] {
      P_HEADER,
      P_INDEX,
      P_COLOUR,
      P_TERM,
      P_DISCARD
   } parse_state_t;

   function automatic logic is_eol(input logic [7:0] b);
      return (b == CHAR_CR) || (b == CHAR_LF);
   endfunction

endpackage

// File: rtl/uart_hex_decode.sv
// ASCII hex digit decoder: 0-9, A-F, a-f to a nibble plus a validity flag.
module uart_hex_decode (
   input  logic [7:0] data,
   output logic [3:0] nibble,
   output logic       is_hex
);

   always_comb begin
      nibble = 4'd0;
      is_hex = 1'b0;
      if (data >= 8'h30 && data <= 8'h39) begin
         nibble = data[3:0];
         is_hex = 1'b1;
      end else if ((data >= 8'h41 && data <= 8'h46) || (data >= 8'h61 && data <= 8'h66)) begin
         // 'A'/'a' have low nibble 1, so +9 lands on 10
         nibble = data[3:0] + 4'd9;
         is_hex = 1'b1;
      end
   end

endmodule

// File: rtl/uart_cmd_parser.sv
// Pulls bytes from the UART RX FIFO and decodes "L<ii><rrggbb><CR|LF>" LED commands.
//
// fetch state | meaning
// F_IDLE      | waiting for the RX FIFO to report data
// F_REQ       | read request issued this cycle
// F_WAIT      | counting down the UART read latency
//
// parse state | meaning
// P_HEADER    | hunting for 'L'
// P_INDEX     | collecting the 2 index digits
// P_COLOUR    | collecting the 6 colour digits
// P_TERM      | expecting CR or LF
// P_DISCARD   | dropping a bad frame until CR or LF
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int unsigned RD_LATENCY = 3
) (
   input  logic        i_Clock,
   input  logic        i_Reset_n,
   input  logic        i_Received,
   input  logic [7:0]  i_Data,
   output logic        o_Read_FIFO,
   output logic        o_Cmd_Valid,
   output logic [7:0]  o_LED_Index,
   output logic [23:0] o_Colour,
   output logic        o_Error,
   output logic        o_Busy
);

   localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(RD_LATENCY);
   localparam logic [2:0]       INDEX_LAST  = 3'(INDEX_DIGITS - 1);
   localparam logic [2:0]       COLOUR_LAST = 3'(COLOUR_DIGITS - 1);

   fetch_state_t     fstate, fstate_nxt;
   logic [LAT_W-1:0] lat_cnt, lat_cnt_nxt;
   logic [7:0]       byte_reg, byte_reg_nxt;
   logic             byte_strobe, byte_strobe_nxt;

   parse_state_t     pstate, pstate_nxt;
   logic [2:0]       dig_cnt, dig_cnt_nxt;
   logic [7:0]       index_sr, index_sr_nxt;
   logic [23:0]      colour_sr, colour_sr_nxt;
   logic             cmd_nxt, err_nxt;

   logic [3:0]       nibble;
   logic             is_hex;

   uart_hex_decode u_hex_decode (
      .data   (byte_reg),
      .nibble (nibble),
      .is_hex (is_hex)
   );

   assign o_Read_FIFO = (fstate == F_REQ);

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         fstate      <= F_IDLE;
         lat_cnt     <= '0;
         byte_reg    <= '0;
         byte_strobe <= 1'b0;
      end else begin
         fstate      <= fstate_nxt;
         lat_cnt     <= lat_cnt_nxt;
         byte_reg    <= byte_reg_nxt;
         byte_strobe <= byte_strobe_nxt;
      end
   end

   always_comb begin
      fstate_nxt      = fstate;
      lat_cnt_nxt     = lat_cnt;
      byte_reg_nxt    = byte_reg;
      byte_strobe_nxt = 1'b0;
      case (fstate)
         F_IDLE: if (i_Received) fstate_nxt = F_REQ;
         F_REQ: begin
            lat_cnt_nxt = LAT_INIT;
            fstate_nxt  = F_WAIT;
         end
         F_WAIT: begin
            lat_cnt_nxt = lat_cnt - 1'b1;
            // sample on the edge where the count reaches zero
            if (lat_cnt == LAT_W'(1)) begin
               byte_reg_nxt    = i_Data;
               byte_strobe_nxt = 1'b1;
               fstate_nxt      = F_IDLE;
            end
         end
         default: fstate_nxt = F_IDLE;
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         pstate      <= P_HEADER;
         dig_cnt     <= '0;
         index_sr    <= '0;
         colour_sr   <= '0;
         o_Cmd_Valid <= 1'b0;
         o_Error     <= 1'b0;
         o_LED_Index <= '0;
         o_Colour    <= '0;
         o_Busy      <= 1'b0;
      end else begin
         pstate      <= pstate_nxt;
         dig_cnt     <= dig_cnt_nxt;
         index_sr    <= index_sr_nxt;
         colour_sr   <= colour_sr_nxt;
         o_Cmd_Valid <= cmd_nxt;
         o_Error     <= err_nxt;
         o_Busy      <= (pstate != P_HEADER);
         if (cmd_nxt) begin
            o_LED_Index <= index_sr;
            o_Colour    <= colour_sr;
         end
      end
   end

   always_comb begin
      pstate_nxt    = pstate;
      dig_cnt_nxt   = dig_cnt;
      index_sr_nxt  = index_sr;
      colour_sr_nxt = colour_sr;
      cmd_nxt       = 1'b0;
      err_nxt       = 1'b0;
      if (byte_strobe) begin
         case (pstate)
            P_HEADER: begin
               if (byte_reg == CHAR_L) begin
                  dig_cnt_nxt   = '0;
                  index_sr_nxt  = '0;
                  colour_sr_nxt = '0;
                  pstate_nxt    = P_INDEX;
               end
            end
            P_INDEX, P_COLOUR: begin
               if (byte_reg == CHAR_L) begin
                  err_nxt       = 1'b1;
                  dig_cnt_nxt   = '0;
                  index_sr_nxt  = '0;
                  colour_sr_nxt = '0;
                  pstate_nxt    = P_INDEX;
               end else if (is_eol(byte_reg)) begin
                  err_nxt    = 1'b1;
                  pstate_nxt = P_HEADER;
               end else if (!is_hex) begin
                  err_nxt    = 1'b1;
                  pstate_nxt = P_DISCARD;
               end else if (pstate == P_INDEX) begin
                  index_sr_nxt = {index_sr[3:0], nibble};
                  if (dig_cnt == INDEX_LAST) begin
                     dig_cnt_nxt = '0;
                     pstate_nxt  = P_COLOUR;
                  end else begin
                     dig_cnt_nxt = dig_cnt + 3'd1;
                  end
               end else begin
                  colour_sr_nxt = {colour_sr[19:0], nibble};
                  if (dig_cnt == COLOUR_LAST) begin
                     dig_cnt_nxt = '0;
                     pstate_nxt  = P_TERM;
                  end else begin
                     dig_cnt_nxt = dig_cnt + 3'd1;
                  end
               end
            end
            P_TERM: begin
               if (is_eol(byte_reg)) begin
                  cmd_nxt    = 1'b1;
                  pstate_nxt = P_HEADER;
               end else if (byte_reg == CHAR_L) begin
                  err_nxt       = 1'b1;
                  dig_cnt_nxt   = '0;
                  index_sr_nxt  = '0;
                  colour_sr_nxt = '0;
                  pstate_nxt    = P_INDEX;
               end else begin
                  err_nxt    = 1'b1;
                  pstate_nxt = P_DISCARD;
               end
            end
            P_DISCARD: if (is_eol(byte_reg)) pstate_nxt = P_HEADER;
            default:   pstate_nxt = P_HEADER;
         endcase
      end
   end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Command parser sitting directly downstream of the UART receiver's RX FIFO. It pulls received bytes one at a time using the UART's read-request / received-flag handshake and parses ASCII LED commands of the form `L` + 2 hex digits (LED index) + 6 hex digits (RGB colour) + CR or LF. Each well-formed command produces a one-cycle command strobe with the decoded index and colour for the LED driver. Malformed frames produce a one-cycle error strobe and are discarded.

## Interface
- RD_LATENCY, 3: cycles from the `o_Read_FIFO` pulse to `i_Data` being valid and sampled (counted from the cycle after the pulse); legal range 1–15.
- i_Clock  in  1  system clock; all logic on rising edge.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_Received  in  1  UART RX FIFO not empty.
- i_Data  in  8  byte returned by the UART after a read request.
- o_Read_FIFO  out  1  one-cycle read request to the UART RX FIFO.
- o_Cmd_Valid  out  1  one-cycle strobe: command decoded.
- o_LED_Index  out  8  LED index of the last valid command; held between strobes.
- o_Colour  out  24  RGB colour {R,G,B} of the last valid command; held between strobes.
- o_Error  out  1  one-cycle strobe: frame aborted.
- o_Busy  out  1  high while a frame is partially received (state not HEADER).

## Operation
- **Fetch FSM states:**
  - F_IDLE: if `i_Received`, go to F_REQ.
  - F_REQ: `o_Read_FIFO`=1 for exactly this cycle; load latency counter with RD_LATENCY; go to F_WAIT.
  - F_WAIT: decrement the counter; at 0, sample `i_Data` into the byte register, pulse an internal `byte_strobe`, and go to F_IDLE.
  - Never more than one outstanding read. `i_Received` is ignored outside F_IDLE.
- **Parse FSM**, advanced only on `byte_strobe`:
  - HEADER:
    - `L` (0x4C): clear the digit counter and shift register; go to INDEX.
    - Any other byte: ignored, no error.
  - INDEX: a hex digit shifts into index_sr[7:0]; after the 2nd digit, go to COLOUR.
  - COLOUR: a hex digit shifts into colour_sr[23:0] MSB-first; after the 6th digit, go to TERM.
  - TERM:
    - CR (0x0D) or LF (0x0A): the next cycle drives `o_Cmd_Valid`=1 and updates `o_LED_Index`/`o_Colour`; go to HEADER.
  - DISCARD: wait for CR/LF, then go to HEADER. No further error strobes. `L` does not resync.
- **Hex digits:** 0–9, A–F, a–f. Nibble = value. Shift is left by 4, new nibble in the LSBs.
- **Error rules.** Each case below pulses `o_Error` for one cycle.
  - In INDEX, COLOUR or TERM, `L` aborts the frame and restarts at INDEX.
  - In INDEX or COLOUR, CR/LF aborts the frame; go to HEADER.
  - Any other non-hex byte in INDEX or COLOUR aborts the frame; go to DISCARD.
  - In TERM, any byte other than CR/LF aborts the frame; go to DISCARD.
- CR/LF in HEADER is ignored. A CR LF pair therefore yields a single command.
- `o_Cmd_Valid` and `o_Error` are mutually exclusive and never asserted in consecutive cycles for the same byte.
- **Reset values:** all outputs 0, both FSMs idle (F_IDLE, HEADER), shift registers 0.
  - Reset mid-frame discards the partial frame with no strobe.
  - A read already requested from the UART before reset is lost; that is acceptable.

## Timing
- Per-byte cost is 2 + RD_LATENCY cycles: F_IDLE→F_REQ→F_WAIT×RD_LATENCY→F_IDLE. That is 5 cycles at default, far below the byte time at 115200 baud.
- `byte_strobe` occurs RD_LATENCY+1 cycles after the `o_Read_FIFO` cycle.
- `o_Cmd_Valid` and `o_Error` are registered and assert 1 cycle after the `byte_strobe` of the deciding byte.
- `o_LED_Index`/`o_Colour` change in the same cycle `o_Cmd_Valid` rises and are stable thereafter.
- `o_Busy` is registered and follows the parse state with 1 cycle delay.

## Structure
- **Package `uart_cmd_pkg`:**
  - character constants CHAR_L, CHAR_CR, CHAR_LF;
  - fetch and parse state encodings;
  - INDEX_DIGITS=2, COLOUR_DIGITS=6.
- **Sub-module `uart_hex_decode`:** combinational. Input 8-bit byte; outputs 4-bit nibble and is_hex flag. Instantiated once.
- Both FSMs, the latency counter, the digit counter (3 bits) and the shift registers live in the top module.

## Test plan
- Bytes "L0AFF8000\r" via the FIFO model with RD_LATENCY=3 → one `o_Cmd_Valid`, `o_LED_Index`=0x0A, `o_Colour`=0xFF8000, `o_Error` never high, each `o_Read_FIFO` one cycle wide.
- "l" lowercase header, then "L03abcdef\r\n" → header ignored; `o_LED_Index`=0x03, `o_Colour`=0xABCDEF; exactly one `o_Cmd_Valid` (LF in HEADER ignored).
- "L1G..." then "L0200FF00\r" → `o_Error` on 'G'; the following 'L' is swallowed by DISCARD; result: no command until CR. Second bench: "L12L0500000F\r" → one `o_Error`, then a command with index 0x05 and colour 0x00000F.
- "L01FF\r" → `o_Error` on CR, no `o_Cmd_Valid`, `o_LED_Index`/`o_Colour` unchanged, `o_Busy` returns to 0.
- Assert `i_Reset_n`=0 asynchronously after "L0A12" → all outputs 0 immediately. After release, "L0B000001\r" → index 0x0B, colour 0x000001.
- `i_Received` held high continuously with 20 queued bytes → read pulses spaced exactly 5 cycles apart (RD_LATENCY=3), no overlapping requests.
